// File: rtl/mips_mc_controller.sv
// mips_mc_controller -- multi-cycle MIPS control path.
//
// A Moore FSM steps each instruction through FETCH/DECODE and an
// instruction-specific tail of execute/memory/write-back states. One memory
// port and one ALU are shared across all phases; the controller drives
// their selects and enables each cycle.
//
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-low reset
//   op, funct       instr[31:26] / instr[5:0] from the instruction register
//   zero            ALU zero flag (branch decision)
//   mem_ready       memory finished the current access this cycle
//   pcen, irwrite, regwrite, memread, memwrite   datapath enables
//   iord, regdst, memtoreg, alusrca, alusrcb, sextend, pcsrc   selects
//   aluop           ALU operation code, zero-extended to ALUOP_W
//   illegal         one-cycle pulse after an unsupported op/funct
//   retired         completed-instruction counter, wraps modulo 2^CNT_W
module mips_mc_controller #(
  parameter int ALUOP_W     = 4,
  parameter bit MEM_WAIT_EN = 1'b1,
  parameter int CNT_W       = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pcen,
  output logic               iord,
  output logic               memread,
  output logic               memwrite,
  output logic               irwrite,
  output logic               regdst,
  output logic               memtoreg,
  output logic               regwrite,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic               sextend,
  output logic [1:0]         pcsrc,
  output logic [ALUOP_W-1:0] aluop,
  output logic               illegal,
  output logic [CNT_W-1:0]   retired
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    RTEXEC, ALUWB, IEXEC, IWB, BRANCH, JUMP
  } state_t;

  localparam logic [3:0] ALU_ADD  = 4'd0,  ALU_SUB  = 4'd1,  ALU_AND = 4'd2,
                         ALU_OR   = 4'd3,  ALU_XOR  = 4'd4,  ALU_NOR = 4'd5,
                         ALU_SLT  = 4'd6,  ALU_SLTU = 4'd7,  ALU_SLL = 4'd8,
                         ALU_SRL  = 4'd9,  ALU_SRA  = 4'd10, ALU_LUI = 4'd11;

  state_t     state, next_state;
  logic       rdy;
  logic [3:0] rt_code;
  logic       rt_legal;
  logic [3:0] imm_code;
  logic       imm_sext;
  logic [3:0] alu_code;

  // With wait-states disabled every memory access completes in one cycle.
  assign rdy = MEM_WAIT_EN ? mem_ready : 1'b1;

  // R-type funct decode; legality is consumed in DECODE, the code in RTEXEC.
  always_comb begin
    rt_legal = 1'b1;
    rt_code  = ALU_ADD;
    case (funct)
      6'h20, 6'h21: rt_code = ALU_ADD;
      6'h22, 6'h23: rt_code = ALU_SUB;
      6'h24:        rt_code = ALU_AND;
      6'h25:        rt_code = ALU_OR;
      6'h26:        rt_code = ALU_XOR;
      6'h27:        rt_code = ALU_NOR;
      6'h2A:        rt_code = ALU_SLT;
      6'h2B:        rt_code = ALU_SLTU;
      6'h00:        rt_code = ALU_SLL;
      6'h02:        rt_code = ALU_SRL;
      6'h03:        rt_code = ALU_SRA;
      default:      rt_legal = 1'b0;
    endcase
  end

  // Immediate-ALU decode: logical ops and lui take a zero-extended imm.
  always_comb begin
    imm_code = ALU_ADD;
    imm_sext = 1'b1;
    case (op)
      6'h0A:   imm_code = ALU_SLT;
      6'h0B:   imm_code = ALU_SLTU;
      6'h0C:   begin imm_code = ALU_AND; imm_sext = 1'b0; end
      6'h0D:   begin imm_code = ALU_OR;  imm_sext = 1'b0; end
      6'h0E:   begin imm_code = ALU_XOR; imm_sext = 1'b0; end
      6'h0F:   begin imm_code = ALU_LUI; imm_sext = 1'b0; end
      default: imm_code = ALU_ADD;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= FETCH;
      illegal <= 1'b0;
      retired <= '0;
    end else begin
      state   <= next_state;
      // DECODE is the only state that can fall straight back to FETCH, and
      // only for an unsupported encoding.
      illegal <= (state == DECODE) && (next_state == FETCH);
      if (next_state == FETCH && state != FETCH && state != DECODE)
        retired <= retired + CNT_W'(1);
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      FETCH:  if (rdy) next_state = DECODE;
      DECODE: begin
        case (op)
          6'h23, 6'h2B:                next_state = MEMADR;
          6'h00:                       next_state = rt_legal ? RTEXEC : FETCH;
          6'h04, 6'h05:                next_state = BRANCH;
          6'h08, 6'h09, 6'h0A, 6'h0B,
          6'h0C, 6'h0D, 6'h0E, 6'h0F:  next_state = IEXEC;
          6'h02:                       next_state = JUMP;
          default:                     next_state = FETCH;
        endcase
      end
      MEMADR: next_state = (op == 6'h23) ? MEMRD : MEMWR;
      MEMRD:  if (rdy) next_state = MEMWB;
      MEMWR:  if (rdy) next_state = FETCH;
      RTEXEC: next_state = ALUWB;
      IEXEC:  next_state = IWB;
      MEMWB, ALUWB, IWB, BRANCH, JUMP: next_state = FETCH;
      default: next_state = FETCH;
    endcase
  end

  // NOTE: every output gets its default before the case so no path through
  // this block can leave a value unassigned and infer a latch.
  always_comb begin
    pcen     = 1'b0;
    iord     = 1'b0;
    memread  = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'd0;
    sextend  = 1'b1;
    pcsrc    = 2'd0;
    alu_code = ALU_ADD;
    case (state)
      FETCH: begin
        memread = 1'b1;
        alusrcb = 2'd1;
        irwrite = rdy;
        pcen    = rdy;
      end
      DECODE: alusrcb = 2'd3;
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'd2;
      end
      MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
      end
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      RTEXEC: begin
        alusrca  = 1'b1;
        alu_code = rt_code;
      end
      ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      IEXEC: begin
        alusrca  = 1'b1;
        alusrcb  = 2'd2;
        sextend  = imm_sext;
        alu_code = imm_code;
      end
      IWB: regwrite = 1'b1;
      BRANCH: begin
        alusrca  = 1'b1;
        alu_code = ALU_SUB;
        pcsrc    = 2'd1;
        pcen     = (op == 6'h05) ? ~zero : zero;
      end
      JUMP: begin
        pcsrc = 2'd2;
        pcen  = 1'b1;
      end
      default: ;
    endcase
    // NOTE: the state register is already FETCH during reset, whose Moore
    // outputs request a read; the enables are masked here so nothing is
    // written or fetched until reset is released.
    if (!reset) begin
      pcen     = 1'b0;
      irwrite  = 1'b0;
      regwrite = 1'b0;
      memwrite = 1'b0;
      memread  = 1'b0;
    end
    aluop = ALUOP_W'(alu_code);
  end

endmodule

// File: doc/mips_mc_controller.md
Name: mips_mc_controller

Overview:
Multi-cycle successor to the single-cycle control path. A Moore FSM sequences each MIPS instruction over 3–5 cycles and shares one memory port and one ALU. It adds the following over the single-cycle controller:
- parametrised ALU-op width
- optional memory wait-states through a ready handshake
- bne and the full immediate ALU set
- illegal-opcode detection
- a retired-instruction counter

It sits beside the multi-cycle datapath, inside the multi-cycle mips top.

Parameters:
- ALUOP_W, 4, width of aluop (≥4); codes are zero-extended into the upper bits.
- MEM_WAIT_EN, 1, 1 = memory states hold until mem_ready=1; 0 = mem_ready is ignored and treated as 1.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk in 1: rising-edge clock.
- reset in 1: asynchronous, active-low reset.
- op in 6: instr[31:26] taken from the instruction register.
- funct in 6: instr[5:0] taken from the instruction register.
- zero in 1: ALU zero flag.
- mem_ready in 1: memory has completed the current access this cycle.
- pcen out 1: PC register load enable.
- iord out 1: memory address select; 0 = PC, 1 = ALUOut.
- memread out 1: memory read request.
- memwrite out 1: memory write request.
- irwrite out 1: instruction register load enable.
- regdst out 1: write-register select; 1 = rd, 0 = rt.
- memtoreg out 1: write-back data select; 1 = MDR, 0 = ALUOut.
- regwrite out 1: register file write enable.
- alusrca out 1: ALU A select; 0 = PC, 1 = rs.
- alusrcb out 2: ALU B select; 0 = rt, 1 = const 4, 2 = extended imm, 3 = sext imm<<2.
- sextend out 1: 1 = sign-extend imm, 0 = zero-extend imm.
- pcsrc out 2: PC source; 0 = ALU result, 1 = ALUOut, 2 = jump target.
- aluop out ALUOP_W: ALU operation code.
- illegal out 1: one-cycle pulse on an unsupported op/funct.
- retired out CNT_W: count of completed instructions.

Behaviour:
- States:
  - FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR
  - RTEXEC, ALUWB, IEXEC, IWB, BRANCH, JUMP
- Reset (reset=0, asynchronous):
  - state=FETCH, retired=0, illegal=0.
  - All enables (pcen, irwrite, regwrite, memwrite, memread) are forced to 0 while reset=0.
- ALU codes:
  - ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOR=5, SLT=6, SLTU=7, SLL=8, SRL=9, SRA=10, LUI=11.
- Default output values in every state: all enables 0, selects 0, aluop=ADD, sextend=1.
- "rdy" means mem_ready, or 1 when MEM_WAIT_EN=0.
- FETCH:
  - Outputs: memread=1, iord=0, alusrca=0, alusrcb=1, pcsrc=0.
  - irwrite=rdy, pcen=rdy.
  - Next state: DECODE if rdy, else stay in FETCH. PC and IR are not updated while stalled.
- DECODE:
  - Outputs: alusrca=0, alusrcb=3, aluop=ADD (precomputes the branch target).
  - Next state by op:
    - 0x23, 0x2B → MEMADR
    - 0x00 with legal funct → RTEXEC
    - 0x04, 0x05 → BRANCH
    - 0x08–0x0F → IEXEC
    - 0x02 → JUMP
    - any other op → FETCH with illegal=1 for one cycle; retired unchanged.
- MEMADR:
  - Outputs: alusrca=1, alusrcb=2, sextend=1, aluop=ADD.
  - Next state: MEMRD if op=0x23, else MEMWR.
- MEMRD:
  - Outputs: memread=1, iord=1.
  - Next state: MEMWB if rdy, else stay.
- MEMWB:
  - Outputs: regdst=0, memtoreg=1, regwrite=1.
  - Next state: FETCH.
- MEMWR:
  - Outputs: iord=1, memwrite=1 (held while stalled).
  - Next state: FETCH when rdy.
- RTEXEC:
  - Outputs: alusrca=1, alusrcb=0.
  - aluop from funct:
    - 0x20, 0x21 → ADD
    - 0x22, 0x23 → SUB
    - 0x24 → AND, 0x25 → OR, 0x26 → XOR, 0x27 → NOR
    - 0x2A → SLT, 0x2B → SLTU
    - 0x00 → SLL, 0x02 → SRL, 0x03 → SRA
  - Other funct values are caught in DECODE: illegal pulse, return to FETCH.
  - Next state: ALUWB.
- ALUWB:
  - Outputs: regdst=1, memtoreg=0, regwrite=1.
  - Next state: FETCH.
- IEXEC:
  - Outputs: alusrca=1, alusrcb=2.
  - By op:
    - 08, 09 → ADD, sext
    - 0A → SLT, sext
    - 0B → SLTU, sext
    - 0C → AND, zext
    - 0D → OR, zext
    - 0E → XOR, zext
    - 0F → LUI, zext
  - Next state: IWB.
- IWB:
  - Outputs: regdst=0, regwrite=1.
  - Next state: FETCH.
- BRANCH:
  - Outputs: alusrca=1, alusrcb=0, aluop=SUB, pcsrc=1.
  - pcen = zero for op 04, ~zero for op 05.
  - Next state: FETCH.
- JUMP:
  - Outputs: pcsrc=2, pcen=1.
  - Next state: FETCH.
- Cycle counts with no wait-states:
  - R-type, I-type and sw: 4 cycles
  - lw: 5 cycles
  - beq, bne and j: 3 cycles
  - Each stall cycle adds 1.
- retired:
  - Increments by 1 on every transition into FETCH from any state except DECODE (the illegal path).
  - Wraps modulo 2^CNT_W.
- Reset mid-instruction:
  - Aborts immediately to FETCH.
  - Any in-flight write is dropped, because enables are forced to 0.
  - retired is cleared.

Test Plan:
- Release reset with mem_ready=1, op=0x00, funct=0x20 → states FETCH, DECODE, RTEXEC, ALUWB; regwrite=1 and regdst=1 in cycle 4; retired=1 after cycle 4.
- lw (op=0x23), MEM_WAIT_EN=1, mem_ready low for 2 cycles in MEMRD → 7 cycles total; memread and iord held at 1 during the stall; regwrite=1 and memtoreg=1 only in MEMWB.
- bne (op=0x05): first with zero=0, then with zero=1 → pcen=1 then pcen=0 in BRANCH; pcsrc=1; 3 cycles each; retired +2.
- op=0x0C (andi), then op=0x0F (lui) → IEXEC shows aluop=2 with sextend=0, then aluop=11 with sextend=0.
- op=0x3F → illegal=1 for one cycle after DECODE; back in FETCH; retired unchanged.
- Assert reset low during MEMWR with mem_ready=0 → memwrite drops to 0 immediately; after reset release, state=FETCH and retired=0. Preload CNT_W=4 with 16 instructions → retired wraps to 0.
